// File: rtl/bsr_meta_cache.sv
`default_nettype none
// ============================================================================
// Module   : bsr_meta_cache
// Purpose  : BSR metadata store; packs DMA words into per-type RAM regions,
//            tracks per-entry valid bits and exports perf/error status.
// Revision : 1.0 - initial release
// ============================================================================
module bsr_meta_cache #(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int ROWPTR_BASE = 0,
    parameter int COLIDX_BASE = 128,
    parameter int BLKHDR_BASE = 448
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_type,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_hit,
    input  logic              clear,
    input  logic              err_clr,
    output logic [ADDR_W:0]   fill_rowptr,
    output logic [ADDR_W:0]   fill_colidx,
    output logic [ADDR_W:0]   fill_blkhdr,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses,
    output logic [31:0]       perf_writes,
    output logic [31:0]       perf_drops,
    output logic              meta_error,
    output logic [3:0]        meta_error_flags
);

    localparam int c_fill_w = ADDR_W + 1;

    localparam logic [1:0] c_type_rowptr = 2'd0;
    localparam logic [1:0] c_type_colidx = 2'd1;
    localparam logic [1:0] c_type_blkhdr = 2'd2;
    localparam logic [1:0] c_type_bad    = 2'd3;

    localparam logic [ADDR_W-1:0] c_rowptr_base = ADDR_W'(ROWPTR_BASE);
    localparam logic [ADDR_W-1:0] c_colidx_base = ADDR_W'(COLIDX_BASE);
    localparam logic [ADDR_W-1:0] c_blkhdr_base = ADDR_W'(BLKHDR_BASE);

    localparam logic [ADDR_W:0] c_rowptr_size = c_fill_w'(COLIDX_BASE - ROWPTR_BASE);
    localparam logic [ADDR_W:0] c_colidx_size = c_fill_w'(BLKHDR_BASE - COLIDX_BASE);
    localparam logic [ADDR_W:0] c_blkhdr_size = c_fill_w'(DEPTH - BLKHDR_BASE);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_hit;
    logic [ADDR_W:0]   r_fill_rowptr;
    logic [ADDR_W:0]   r_fill_colidx;
    logic [ADDR_W:0]   r_fill_blkhdr;
    logic [31:0]       r_hits;
    logic [31:0]       r_misses;
    logic [31:0]       r_writes;
    logic [31:0]       r_drops;
    logic [2:0]        r_flags;

    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W:0]   w_size;
    logic [ADDR_W:0]   w_fill;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_accept;
    logic              w_bad_type;
    logic              w_full;
    logic              w_overflow;
    logic              w_write;
    logic              w_drop;
    logic              w_rd_hit;
    logic              w_rd_miss;
    logic [2:0]        w_new_err;

    function automatic logic [31:0] f_sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Region selection for the incoming word's type
    always_comb begin
        w_base = c_rowptr_base;
        w_size = c_rowptr_size;
        w_fill = r_fill_rowptr;
        case (in_type)
            c_type_colidx: begin
                w_base = c_colidx_base;
                w_size = c_colidx_size;
                w_fill = r_fill_colidx;
            end
            c_type_blkhdr: begin
                w_base = c_blkhdr_base;
                w_size = c_blkhdr_size;
                w_fill = r_fill_blkhdr;
            end
            default: ;
        endcase
    end

    assign in_ready   = !clear;
    assign w_accept   = in_valid && in_ready;
    assign w_bad_type = w_accept && (in_type == c_type_bad);
    assign w_full     = (w_fill == w_size);
    assign w_overflow = w_accept && !w_bad_type && w_full;
    assign w_write    = w_accept && !w_bad_type && !w_full;
    assign w_drop     = w_bad_type || w_overflow;
    assign w_wr_addr  = w_base + w_fill[ADDR_W-1:0];
    assign w_rd_hit   = rd_en && r_vld[rd_addr];
    assign w_rd_miss  = rd_en && !r_vld[rd_addr];
    assign w_new_err  = {w_rd_miss, w_overflow, w_bad_type};

    // Storage array carries no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[w_wr_addr] <= in_data;
        end
    end

    // Nonblocking read sees pre-write data and pre-clear valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_hit   <= w_rd_hit;
            if (rd_en) begin
                r_rd_data <= r_mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld         <= '0;
            r_fill_rowptr <= '0;
            r_fill_colidx <= '0;
            r_fill_blkhdr <= '0;
        end else if (clear) begin
            r_vld         <= '0;
            r_fill_rowptr <= '0;
            r_fill_colidx <= '0;
            r_fill_blkhdr <= '0;
        end else if (w_write) begin
            r_vld[w_wr_addr] <= 1'b1;
            case (in_type)
                c_type_rowptr: r_fill_rowptr <= w_fill + 1'b1;
                c_type_colidx: r_fill_colidx <= w_fill + 1'b1;
                c_type_blkhdr: r_fill_blkhdr <= w_fill + 1'b1;
                default: ;
            endcase
        end
    end

    // A new error in the err_clr cycle survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hits   <= '0;
            r_misses <= '0;
            r_writes <= '0;
            r_drops  <= '0;
            r_flags  <= '0;
        end else begin
            r_hits   <= f_sat_inc(r_hits, w_rd_hit);
            r_misses <= f_sat_inc(r_misses, w_rd_miss);
            r_writes <= f_sat_inc(r_writes, w_write);
            r_drops  <= f_sat_inc(r_drops, w_drop);
            r_flags  <= (err_clr ? 3'b000 : r_flags) | w_new_err;
        end
    end

    assign rd_data          = r_rd_data;
    assign rd_valid         = r_rd_valid;
    assign rd_hit           = r_rd_hit;
    assign fill_rowptr      = r_fill_rowptr;
    assign fill_colidx      = r_fill_colidx;
    assign fill_blkhdr      = r_fill_blkhdr;
    assign perf_hits        = r_hits;
    assign perf_misses      = r_misses;
    assign perf_writes      = r_writes;
    assign perf_drops       = r_drops;
    assign meta_error       = |r_flags;
    assign meta_error_flags = {1'b0, r_flags};

endmodule
`default_nettype wire
